// File: rtl/uart_tx_fifo_feeder.sv
// Byte FIFO that paces bytes into the UART transmit controller using its Start/Empty handshake.
// Producers may burst up to DEPTH bytes; drops on a full FIFO set a sticky Overflow flag.
module uart_tx_fifo_feeder #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          Push,
  input  logic [7:0]    Push_data,
  output logic          Full,
  output logic [CW-1:0] Count,
  output logic          Overflow,
  output logic          Busy,
  output logic          TX_start,
  output logic [7:0]    TX_data,
  input  logic          TX_empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [1:0] {StIdle, StReq, StBusy} state_e;

  state_e          state_q, state_d;
  logic [7:0]      mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q, count_d;
  logic            full_q, full_d;
  logic            overflow_q;
  logic            busy_q, busy_d;
  logic            tx_start_q, tx_start_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            push_ok, pop;

  // Acceptance uses the registered Full so a pop on the same edge cannot make room.
  assign push_ok = Push && !full_q;

  always_comb begin
    state_d    = state_q;
    tx_start_d = tx_start_q;
    tx_data_d  = tx_data_q;
    pop        = 1'b0;
    case (state_q)
      StIdle: begin
        tx_start_d = 1'b0;
        if (count_q != '0 && TX_empty) begin
          tx_data_d  = mem_q[rd_ptr_q];
          tx_start_d = 1'b1;
          state_d    = StReq;
        end
      end
      StReq: begin
        // Empty falling means the controller has latched TX_data.
        if (!TX_empty) begin
          tx_start_d = 1'b0;
          pop        = 1'b1;
          state_d    = StBusy;
        end
      end
      StBusy: begin
        if (TX_empty) state_d = StIdle;
      end
      default: begin
        tx_start_d = 1'b0;
        state_d    = StIdle;
      end
    endcase
  end

  always_comb begin
    count_d = count_q;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    full_d = (count_d == CW'(DEPTH));
    busy_d = (count_d != '0) || (state_d != StIdle);
  end

  always_ff @(posedge Clock) begin
    if (push_ok) mem_q[wr_ptr_q] <= Push_data;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q    <= StIdle;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      full_q     <= full_d;
      busy_q     <= busy_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      if (Push && full_q) overflow_q <= 1'b1;
    end
  end

  assign Full     = full_q;
  assign Count    = count_q;
  assign Overflow = overflow_q;
  assign Busy     = busy_q;
  assign TX_start = tx_start_q;
  assign TX_data  = tx_data_q;

endmodule

// File: tb/tb_uart_tx_fifo_feeder.sv
// Directed bench for uart_tx_fifo_feeder: a cycle table for single/burst handshakes, then
// sequences for full/overflow, simultaneous push/pop, pointer wrap and mid-transfer reset.
module tb_uart_tx_fifo_feeder;

  localparam int DEPTH = 16;
  localparam int CW    = 5;

  logic          Clock = 1'b0;
  logic          Reset;
  logic          Push;
  logic [7:0]    Push_data;
  logic          Full;
  logic [CW-1:0] Count;
  logic          Overflow;
  logic          Busy;
  logic          TX_start;
  logic [7:0]    TX_data;
  logic          TX_empty;

  logic force_busy;
  logic ctrl_empty;
  logic ctrl_en;
  assign TX_empty = ctrl_empty && !force_busy;

  uart_tx_fifo_feeder #(.DEPTH(DEPTH)) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .Push      (Push),
    .Push_data (Push_data),
    .Full      (Full),
    .Count     (Count),
    .Overflow  (Overflow),
    .Busy      (Busy),
    .TX_start  (TX_start),
    .TX_data   (TX_data),
    .TX_empty  (TX_empty)
  );

  always #5 Clock = ~Clock;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Simple stand-in for the transmit controller: latch on Start, stay busy four cycles.
  logic [7:0] got_q[$];
  initial begin
    ctrl_empty = 1'b1;
    forever begin
      @(negedge Clock);
      if (ctrl_en && TX_start && TX_empty) begin
        got_q.push_back(TX_data);
        ctrl_empty = 1'b0;
        repeat (4) @(negedge Clock);
        ctrl_empty = 1'b1;
      end
    end
  end

  int         start_rises = 0;
  logic       prev_start = 1'b0;
  logic [7:0] prev_data = 8'h00;
  initial begin
    forever begin
      @(negedge Clock);
      if (TX_start === 1'b1 && prev_start === 1'b1) check("tx_data_stable", TX_data, prev_data);
      if (TX_start === 1'b1 && prev_start !== 1'b1) start_rises++;
      prev_start = TX_start;
      prev_data  = TX_data;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic          push;
    logic [7:0]    data;
    logic          empty;
    logic          full;
    logic [CW-1:0] count;
    logic          ov;
    logic          busy;
    logic          start;
    logic [7:0]    txd;
  } vec_t;

  vec_t       vecs[21];
  logic [7:0] exp_q[$];

  task automatic wait_drain(input string name);
    int n = 0;
    while (!(Count == 0 && !Busy && ctrl_empty) && n < 3000) begin
      @(negedge Clock);
      n++;
    end
    check({name, " drain_timeout"}, 32'(n < 3000), 32'd1);
  endtask

  task automatic compare_stream(input string name);
    check({name, " byte_count"}, got_q.size(), exp_q.size());
    check({name, " start_count"}, start_rises, exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s byte%0d", name, i), got_q[i], exp_q[i]);
  endtask

  initial begin
    //            push  data   emp   full  cnt    ov    busy  start txd
    vecs[0]  = '{1'b1, 8'hA5, 1'b1, 1'b0, 5'd1,  1'b0, 1'b1, 1'b0, 8'h00};
    vecs[1]  = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd1,  1'b0, 1'b1, 1'b1, 8'hA5};
    vecs[2]  = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd1,  1'b0, 1'b1, 1'b1, 8'hA5};
    vecs[3]  = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 8'hA5};
    vecs[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 8'hA5};
    vecs[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 8'hA5};
    vecs[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 8'hA5};
    vecs[7]  = '{1'b1, 8'h11, 1'b1, 1'b0, 5'd1,  1'b0, 1'b1, 1'b0, 8'hA5};
    vecs[8]  = '{1'b1, 8'h22, 1'b1, 1'b0, 5'd2,  1'b0, 1'b1, 1'b1, 8'h11};
    vecs[9]  = '{1'b1, 8'h33, 1'b1, 1'b0, 5'd3,  1'b0, 1'b1, 1'b1, 8'h11};
    vecs[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd3,  1'b0, 1'b1, 1'b1, 8'h11};
    vecs[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd2,  1'b0, 1'b1, 1'b0, 8'h11};
    vecs[12] = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd2,  1'b0, 1'b1, 1'b0, 8'h11};
    vecs[13] = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd2,  1'b0, 1'b1, 1'b0, 8'h11};
    vecs[14] = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd2,  1'b0, 1'b1, 1'b1, 8'h22};
    vecs[15] = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd1,  1'b0, 1'b1, 1'b0, 8'h22};
    vecs[16] = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd1,  1'b0, 1'b1, 1'b0, 8'h22};
    vecs[17] = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd1,  1'b0, 1'b1, 1'b0, 8'h22};
    vecs[18] = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd1,  1'b0, 1'b1, 1'b1, 8'h33};
    vecs[19] = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 8'h33};
    vecs[20] = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 8'h33};

    Reset = 1'b1; Push = 1'b0; Push_data = 8'h00; force_busy = 1'b0; ctrl_en = 1'b0;
    repeat (2) @(negedge Clock);
    check("reset Full", Full, 0);
    check("reset Count", Count, 0);
    check("reset Overflow", Overflow, 0);
    check("reset Busy", Busy, 0);
    check("reset TX_start", TX_start, 0);
    check("reset TX_data", TX_data, 8'h00);
    Reset = 1'b0;

    // Single byte and burst handshakes, one table row per clock.
    for (int i = 0; i < 21; i++) begin
      Push = vecs[i].push; Push_data = vecs[i].data; force_busy = !vecs[i].empty;
      @(negedge Clock);
      check($sformatf("v%0d Full", i), Full, vecs[i].full);
      check($sformatf("v%0d Count", i), Count, vecs[i].count);
      check($sformatf("v%0d Overflow", i), Overflow, vecs[i].ov);
      check($sformatf("v%0d Busy", i), Busy, vecs[i].busy);
      check($sformatf("v%0d TX_start", i), TX_start, vecs[i].start);
      check($sformatf("v%0d TX_data", i), TX_data, vecs[i].txd);
    end
    Push = 1'b0; force_busy = 1'b0;

    // Fill with the controller held busy, then overflow.
    force_busy = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      Push = 1'b1; Push_data = 8'(i);
      @(negedge Clock);
    end
    Push = 1'b0;
    check("fill Full", Full, 1);
    check("fill Count", Count, 16);
    check("fill TX_start", TX_start, 0);
    check("fill Overflow", Overflow, 0);
    Push = 1'b1; Push_data = 8'hFF;
    @(negedge Clock);
    Push = 1'b0;
    check("ovf Overflow", Overflow, 1);
    check("ovf Count", Count, 16);
    check("ovf Full", Full, 1);

    // Push on the pop edge while full is rejected.
    force_busy = 1'b0;
    @(negedge Clock);
    check("req16 TX_start", TX_start, 1);
    check("req16 TX_data", TX_data, 8'h00);
    check("req16 Count", Count, 16);
    Push = 1'b1; Push_data = 8'h5A; force_busy = 1'b1;
    @(negedge Clock);
    Push = 1'b0;
    check("pop16 Count", Count, 15);
    check("pop16 Full", Full, 0);
    check("pop16 TX_start", TX_start, 0);
    force_busy = 1'b0;
    @(negedge Clock);
    @(negedge Clock);
    check("req15 TX_start", TX_start, 1);
    check("req15 TX_data", TX_data, 8'h01);
    check("req15 Count", Count, 15);
    // With room available, push and pop on the same edge leave Count unchanged.
    Push = 1'b1; Push_data = 8'h5B; force_busy = 1'b1;
    @(negedge Clock);
    Push = 1'b0;
    check("pushpop Count", Count, 15);
    check("pushpop TX_start", TX_start, 0);

    got_q.delete(); exp_q.delete(); start_rises = 0;
    for (int i = 2; i < DEPTH; i++) exp_q.push_back(8'(i));
    exp_q.push_back(8'h5B);
    ctrl_en = 1'b1; force_busy = 1'b0;
    wait_drain("drain1");
    compare_stream("drain1");

    // Wrap-around: DEPTH+5 bytes pushed whenever there is room.
    got_q.delete(); exp_q.delete(); start_rises = 0;
    for (int i = 0; i < DEPTH + 5; i++) begin
      int n = 0;
      while (Full && n < 100) begin
        @(negedge Clock);
        n++;
      end
      Push = 1'b1; Push_data = 8'h40 + 8'(i);
      exp_q.push_back(8'h40 + 8'(i));
      @(negedge Clock);
      Push = 1'b0;
    end
    wait_drain("wrap");
    compare_stream("wrap");
    check("wrap Count", Count, 0);
    check("wrap Full", Full, 0);

    // Reset during the second byte's busy phase.
    got_q.delete(); start_rises = 0;
    for (int i = 0; i < 4; i++) begin
      Push = 1'b1; Push_data = 8'hC0 + 8'(i);
      @(negedge Clock);
    end
    Push = 1'b0;
    begin
      int n = 0;
      while (got_q.size() < 2 && n < 200) begin
        @(negedge Clock);
        n++;
      end
      check("rst wait_second", 32'(n < 200), 32'd1);
    end
    @(negedge Clock);
    check("prerst Count", Count, 2);
    check("prerst Overflow", Overflow, 1);
    check("prerst TX_start", TX_start, 0);
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    check("rst TX_start", TX_start, 0);
    check("rst Count", Count, 0);
    check("rst Overflow", Overflow, 0);
    check("rst Busy", Busy, 0);
    check("rst Full", Full, 0);
    start_rises = 0;
    repeat (30) @(negedge Clock);
    check("rst no_start", start_rises, 0);
    check("rst bytes_sent", got_q.size(), 2);
    check("rst Busy_later", Busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo_feeder.md
Name: uart_tx_fifo_feeder

Overview:
- Byte buffer and sequencer that sits directly upstream of the UART transmit controller.
- Accepts bytes from a producer (e.g. a message formatter or SRAM reader) into a FIFO.
- Presents bytes one at a time on the controller's Start/TX_data interface and watches its Empty flag to pace transfers.
- Lets producers burst data without tracking the slow, baud-paced serializer.

Parameters:
- DEPTH, 16, number of FIFO entries; must be a power of two, 2 or more.
- CW, $clog2(DEPTH+1), width of the Count output (derived; do not override).

Ports:
- Clock  input  1  system clock (same clock as the transmit controller).
- Reset  input  1  synchronous, active-high reset.
- Push  input  1  producer writes Push_data this cycle.
- Push_data  input  8  byte to enqueue.
- Full  output  1  FIFO holds DEPTH bytes.
- Count  output  CW  number of bytes currently queued, excluding the byte in flight.
- Overflow  output  1  sticky; set when a Push is dropped.
- Busy  output  1  high when FIFO is non-empty or the FSM is not in S_IDLE.
- TX_start  output  1  connects to the controller's Start input.
- TX_data  output  8  connects to the controller's TX_data input.
- TX_empty  input  1  connects from the controller's Empty output.

Behaviour:
- Clock and reset
  - One clock domain; all state updates on posedge Clock.
  - Reset is synchronous, active-high.
  - Reset values: Full=0, Count=0, Overflow=0, Busy=0, TX_start=0, TX_data=8'h00, FSM=S_IDLE, read/write pointers=0.
- FIFO
  - Circular buffer with log2(DEPTH)-bit pointers that wrap naturally.
  - Count, Full and Busy are registered.
  - Push is accepted only when Full=0 at that edge.
  - An accepted push writes mem[wr_ptr], increments wr_ptr, and increments Count unless a pop occurs on the same edge.
  - Push while Full=1: data is dropped, pointers and Count are unchanged, Overflow<=1. Overflow clears only on Reset.
  - Pop and accepted push on the same edge: Count is unchanged and both pointers advance.
  - Push into an empty FIFO: Count=1 in the following cycle. There is no bypass; data always passes through mem.
- FSM states
  - S_IDLE: TX_start=0. If Count!=0 and TX_empty=1: TX_data<=mem[rd_ptr], TX_start<=1, go to S_REQ. Otherwise stay.
  - S_REQ: TX_start and TX_data are held stable. Stay until TX_empty=0, which means the controller has latched the byte. On that edge: TX_start<=0, rd_ptr++, Count-- (the pop), go to S_BUSY.
  - S_BUSY: wait for TX_empty=1, which means the stop bit is being driven and the controller is returning to idle. Then go to S_IDLE.
  - Any undefined state goes to S_IDLE.
- Timing
  - Push at edge N into an empty FIFO with TX_empty=1: Count=1 after N, TX_start=1 after edge N+1.
  - Minimum gap between consecutive TX_start assertions is one idle cycle. Back-to-back bytes are therefore limited only by the controller.
  - TX_start may stay high across many Clock cycles while the controller's TX_clock_enable is low. This is legal; the controller samples Start only on enable cycles.
- Boundary conditions
  - TX_empty=0 on entry to S_IDLE (controller still busy from an external source) blocks issue until it returns to 1.
  - Reset mid-transfer: the FIFO is flushed, TX_start drops the cycle after Reset, and the byte in flight is not re-queued. The system reset drives both blocks.

Test Plan:
1. Single byte. Push 8'hA5 once with the real transmit controller attached.
   - TX_start=1 two edges after the push, with TX_data=8'hA5.
   - TX_start deasserts the edge after TX_empty falls; Count returns to 0.
   - UART line shows 0, 1,0,1,0,0,1,0,1, 1.
   - Busy=0 once TX_empty=1 again.
2. Burst ordering. Push 8'h11, 8'h22, 8'h33 on consecutive cycles.
   - Count reads 3.
   - Serial output order is 11, 22, 33, with exactly one TX_start per byte.
   - TX_data never changes while TX_start=1.
3. Full and overflow. Hold TX_empty=0 and push 8'h00..8'h0F.
   - Full=1 and Count=16.
   - A 17th push of 8'hFF sets Overflow=1 and leaves Count=16.
   - After release, the 16 bytes drain in order and 8'hFF never appears.
4. Simultaneous push/pop. With Count=16 and S_REQ, push 8'h5A on the same edge TX_empty falls.
   - Push is rejected (Full=1 at that edge) and Overflow=1.
   - Repeat with Count=15: push accepted and Count stays 15.
5. Wrap-around. Push and drain DEPTH+5 bytes with an incrementing pattern.
   - Output sequence is exact across the pointer wrap.
   - Count=0 and Full=0 at the end.
6. Reset mid-operation. Queue 4 bytes and assert Reset during the second byte's S_BUSY.
   - Next cycle: TX_start=0, Count=0, Overflow=0, Busy=0.
   - No further TX_start until a new push.
